// File: rtl/usr_axil_master_if.sv
// ---------------------------------------------------------------------------
// usr_axil_master_if
// Purpose : AXI4-Lite bus bundle between usr_axil_master and the user
//           register block. Carries the five AXI-Lite channels.
// Signals :
//   AW : awaddr[31:0], awprot[2:0], awvalid  (master -> slave), awready (slave -> master)
//   W  : wdata[31:0], wstrb[3:0], wvalid     (master -> slave), wready  (slave -> master)
//   B  : bvalid, bresp[1:0]                  (slave -> master), bready  (master -> slave)
//   AR : araddr[31:0], arprot[2:0], arvalid  (master -> slave), arready (slave -> master)
//   R  : rdata[31:0], rresp[1:0], rvalid     (slave -> master), rready  (master -> slave)
// Modports: master (used by usr_axil_master), slave (used by the register block).
// ---------------------------------------------------------------------------
interface usr_axil_master_if;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;

    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;

    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output araddr, arprot, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  araddr, arprot, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );
endinterface

// File: rtl/usr_axil_master.sv
// ---------------------------------------------------------------------------
// usr_axil_master
// Purpose : Turns single host register-access commands into AXI4-Lite write
//           or read transactions. One transaction in flight at a time, with a
//           per-transaction timeout and a saturating error counter.
// Parameters:
//   TIMEOUT_CYC : cycles allowed in the bus-phase states before abort (>=2)
//   ERRCNT_W    : width of err_cnt_o
// Ports:
//   usr_clk, usr_rst          : clock, asynchronous active-high reset
//   cmd_valid_i / cmd_ready_o : command handshake
//   cmd_wr_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i : command fields
//   rsp_valid_o / rsp_ready_i : response handshake
//   rsp_rdata_o, rsp_resp_o, rsp_timeout_o         : response fields
//   err_cnt_o                 : saturating count of error/timeout responses
//   m_axil                    : AXI4-Lite master bus (usr_axil_master_if.master)
// ---------------------------------------------------------------------------
module usr_axil_master #(
    parameter int TIMEOUT_CYC = 256,
    parameter int ERRCNT_W    = 16
) (
    input  logic                  usr_clk,
    input  logic                  usr_rst,

    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_wr_i,
    input  logic [31:0]           cmd_addr_i,
    input  logic [31:0]           cmd_wdata_i,
    input  logic [3:0]            cmd_wstrb_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_rdata_o,
    output logic [1:0]            rsp_resp_o,
    output logic                  rsp_timeout_o,
    output logic [ERRCNT_W-1:0]   err_cnt_o,

    usr_axil_master_if.master     m_axil
);

    // Counter only needs to reach TIMEOUT_CYC-1 before the abort fires.
    localparam int                 TCNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TCNT_W-1:0]  TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]         RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;

    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wstrb;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_bready;
    logic                r_arvalid;
    logic                r_rready;
    logic [TCNT_W-1:0]   r_tcnt;
    logic [31:0]         r_rsp_rdata;
    logic [1:0]          r_rsp_resp;
    logic                r_rsp_timeout;
    logic [ERRCNT_W-1:0] r_err_cnt;

    logic                w_accept;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_b_hs;
    logic                w_ar_hs;
    logic                w_r_hs;
    logic                w_aw_pend;
    logic                w_w_pend;
    logic                w_tmo_hit;
    logic                w_tmo_abort;
    logic                w_err_evt;
    logic                w_bus_nxt;

    assign w_accept  = (r_state == IDLE) && cmd_valid_i;
    assign w_aw_hs   = r_awvalid && m_axil.awready;
    assign w_w_hs    = r_wvalid  && m_axil.wready;
    assign w_b_hs    = r_bready  && m_axil.bvalid;
    assign w_ar_hs   = r_arvalid && m_axil.arready;
    assign w_r_hs    = r_rready  && m_axil.rvalid;
    // A channel is still pending if its valid is up and it does not complete now.
    assign w_aw_pend = r_awvalid && !w_aw_hs;
    assign w_w_pend  = r_wvalid  && !w_w_hs;
    assign w_tmo_hit = (r_tcnt == TCNT_LAST);

    // Next-state: a completing handshake always takes priority over expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_tmo_abort = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid_i) begin
                    w_state_nxt = cmd_wr_i ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                if (!w_aw_pend && !w_w_pend) begin
                    w_state_nxt = WR_RESP;
                end else if (w_tmo_hit) begin
                    w_state_nxt = RSP;
                    w_tmo_abort = 1'b1;
                end
            end
            WR_RESP: begin
                if (w_b_hs) begin
                    w_state_nxt = RSP;
                end else if (w_tmo_hit) begin
                    w_state_nxt = RSP;
                    w_tmo_abort = 1'b1;
                end
            end
            RD_REQ: begin
                if (w_ar_hs) begin
                    w_state_nxt = RD_RESP;
                end else if (w_tmo_hit) begin
                    w_state_nxt = RSP;
                    w_tmo_abort = 1'b1;
                end
            end
            RD_RESP: begin
                if (w_r_hs) begin
                    w_state_nxt = RSP;
                end else if (w_tmo_hit) begin
                    w_state_nxt = RSP;
                    w_tmo_abort = 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_err_evt = w_tmo_abort
                    || ((r_state == WR_RESP) && w_b_hs && (m_axil.bresp != 2'b00))
                    || ((r_state == RD_RESP) && w_r_hs && (m_axil.rresp != 2'b00));

    assign w_bus_nxt = (w_state_nxt == WR_REQ)  || (w_state_nxt == WR_RESP)
                    || (w_state_nxt == RD_REQ)  || (w_state_nxt == RD_RESP);

    always_ff @(posedge usr_clk or posedge usr_rst) begin
        if (usr_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Bus handshake outputs are derived from the next state so that an abort
    // (next state RSP) drops every valid/ready on the same edge.
    always_ff @(posedge usr_clk or posedge usr_rst) begin
        if (usr_rst) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
        end else begin
            r_awvalid <= (w_state_nxt == WR_REQ) && (w_accept || w_aw_pend);
            r_wvalid  <= (w_state_nxt == WR_REQ) && (w_accept || w_w_pend);
            r_bready  <= (w_state_nxt == WR_RESP);
            r_arvalid <= (w_state_nxt == RD_REQ);
            r_rready  <= (w_state_nxt == RD_RESP);
        end
    end

    // Command fields are captured only on accept and held for the whole
    // transaction, keeping addr/data/strb stable while valids are high.
    always_ff @(posedge usr_clk or posedge usr_rst) begin
        if (usr_rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
        end else if (w_accept) begin
            r_addr  <= cmd_addr_i;
            r_wdata <= cmd_wdata_i;
            r_wstrb <= cmd_wstrb_i;
        end
    end

    always_ff @(posedge usr_clk or posedge usr_rst) begin
        if (usr_rst) begin
            r_tcnt <= '0;
        end else if (w_accept) begin
            r_tcnt <= '0;
        end else if (w_bus_nxt) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    always_ff @(posedge usr_clk or posedge usr_rst) begin
        if (usr_rst) begin
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= 2'b00;
            r_rsp_timeout <= 1'b0;
        end else if (w_tmo_abort) begin
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= RESP_SLVERR;
            r_rsp_timeout <= 1'b1;
        end else if ((r_state == WR_RESP) && w_b_hs) begin
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= m_axil.bresp;
            r_rsp_timeout <= 1'b0;
        end else if ((r_state == RD_RESP) && w_r_hs) begin
            r_rsp_rdata   <= m_axil.rdata;
            r_rsp_resp    <= m_axil.rresp;
            r_rsp_timeout <= 1'b0;
        end
    end

    always_ff @(posedge usr_clk or posedge usr_rst) begin
        if (usr_rst) begin
            r_err_cnt <= '0;
        end else if (w_err_evt) begin
            r_err_cnt <= sat_inc(r_err_cnt);
        end
    end

    // cmd_ready is held low while reset is asserted so that no command can be
    // seen as accepted during reset.
    assign cmd_ready_o    = (r_state == IDLE) && !usr_rst;
    assign rsp_valid_o    = (r_state == RSP);
    assign rsp_rdata_o    = r_rsp_rdata;
    assign rsp_resp_o     = r_rsp_resp;
    assign rsp_timeout_o  = r_rsp_timeout;
    assign err_cnt_o      = r_err_cnt;

    assign m_axil.awaddr  = r_addr;
    assign m_axil.awprot  = 3'b000;
    assign m_axil.awvalid = r_awvalid;
    assign m_axil.wdata   = r_wdata;
    assign m_axil.wstrb   = r_wstrb;
    assign m_axil.wvalid  = r_wvalid;
    assign m_axil.bready  = r_bready;
    assign m_axil.araddr  = r_addr;
    assign m_axil.arprot  = 3'b000;
    assign m_axil.arvalid = r_arvalid;
    assign m_axil.rready  = r_rready;

endmodule

// File: tb/tb_usr_axil_master.sv
`timescale 1ns/1ps
module tb_usr_axil_master;

    localparam int TMO = 16;

    logic        usr_clk = 1'b0;
    logic        usr_rst;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_wr_i;
    logic [31:0] cmd_addr_i;
    logic [31:0] cmd_wdata_i;
    logic [3:0]  cmd_wstrb_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic [1:0]  rsp_resp_o;
    logic        rsp_timeout_o;
    logic [15:0] err_cnt_o;

    usr_axil_master_if bus();

    usr_axil_master #(.TIMEOUT_CYC(TMO), .ERRCNT_W(16)) dut (
        .usr_clk       (usr_clk),
        .usr_rst       (usr_rst),
        .cmd_valid_i   (cmd_valid_i),
        .cmd_ready_o   (cmd_ready_o),
        .cmd_wr_i      (cmd_wr_i),
        .cmd_addr_i    (cmd_addr_i),
        .cmd_wdata_i   (cmd_wdata_i),
        .cmd_wstrb_i   (cmd_wstrb_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_resp_o    (rsp_resp_o),
        .rsp_timeout_o (rsp_timeout_o),
        .err_cnt_o     (err_cnt_o),
        .m_axil        (bus)
    );

    always #5 usr_clk = ~usr_clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Slave model configuration
    logic        cfg_toggle   = 1'b0;
    int          cfg_aw_dly   = 0;
    int          cfg_w_dly    = 0;
    int          cfg_ar_dly   = 0;
    logic        cfg_ar_never = 1'b0;
    logic        cfg_b_hold   = 1'b0;
    logic [1:0]  cfg_bresp    = 2'b00;
    logic [1:0]  cfg_rresp    = 2'b00;
    logic [31:0] cfg_rdata    = 32'h0;

    logic        tgl     = 1'b0;
    int          aw_wait = 0;
    int          w_wait  = 0;
    int          ar_wait = 0;

    int          aw_cnt  = 0;
    int          w_cnt   = 0;
    int          b_cnt   = 0;
    int          ar_cnt  = 0;
    int          r_cnt   = 0;
    int          rsp_cnt = 0;
    logic [31:0] mon_awaddr = 32'h0;
    logic [31:0] mon_wdata  = 32'h0;
    logic [3:0]  mon_wstrb  = 4'h0;
    logic [31:0] mon_araddr = 32'h0;

    // Slave: drives its outputs on the falling edge, away from the DUT edge.
    always @(negedge usr_clk) begin
        tgl     <= ~tgl;
        aw_wait <= bus.awvalid ? aw_wait + 1 : 0;
        w_wait  <= bus.wvalid  ? w_wait + 1  : 0;
        ar_wait <= bus.arvalid ? ar_wait + 1 : 0;
        bus.awready <= cfg_toggle ? ~tgl : (bus.awvalid && (aw_wait >= cfg_aw_dly));
        bus.wready  <= cfg_toggle ? ~tgl : (bus.wvalid  && (w_wait  >= cfg_w_dly));
        bus.arready <= !cfg_ar_never &&
                       (cfg_toggle ? ~tgl : (bus.arvalid && (ar_wait >= cfg_ar_dly)));
        bus.bvalid  <= !cfg_b_hold && (aw_cnt > b_cnt) && (w_cnt > b_cnt);
        bus.bresp   <= cfg_bresp;
        bus.rvalid  <= (ar_cnt > r_cnt);
        bus.rdata   <= cfg_rdata;
        bus.rresp   <= cfg_rresp;
    end

    // Handshake monitor
    always @(posedge usr_clk) begin
        if (usr_rst) begin
            aw_cnt  <= 0;
            w_cnt   <= 0;
            b_cnt   <= 0;
            ar_cnt  <= 0;
            r_cnt   <= 0;
            rsp_cnt <= 0;
        end else begin
            if (bus.awvalid && bus.awready) begin
                aw_cnt     <= aw_cnt + 1;
                mon_awaddr <= bus.awaddr;
            end
            if (bus.wvalid && bus.wready) begin
                w_cnt     <= w_cnt + 1;
                mon_wdata <= bus.wdata;
                mon_wstrb <= bus.wstrb;
            end
            if (bus.bvalid && bus.bready) b_cnt <= b_cnt + 1;
            if (bus.arvalid && bus.arready) begin
                ar_cnt     <= ar_cnt + 1;
                mon_araddr <= bus.araddr;
            end
            if (bus.rvalid && bus.rready) r_cnt <= r_cnt + 1;
            if (rsp_valid_o && rsp_ready_i) rsp_cnt <= rsp_cnt + 1;
        end
    end

    task automatic send_cmd(input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb);
        int n;
        @(negedge usr_clk);
        cmd_valid_i = 1'b1;
        cmd_wr_i    = wr;
        cmd_addr_i  = addr;
        cmd_wdata_i = data;
        cmd_wstrb_i = strb;
        n = 0;
        while (cmd_ready_o !== 1'b1 && n < 50) begin
            @(negedge usr_clk);
            n++;
        end
        if (cmd_ready_o !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cmd_accept: cmd_ready_o=%b after %0d cycles, required 1", cmd_ready_o, n);
        end
        @(posedge usr_clk);
        @(negedge usr_clk);
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(output bit ok);
        int n;
        n = 0;
        while (rsp_valid_o !== 1'b1 && n < 100) begin
            @(negedge usr_clk);
            n++;
        end
        ok = (rsp_valid_o === 1'b1);
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rsp_wait: rsp_valid_o=%b after %0d cycles, required 1", rsp_valid_o, n);
        end
    endtask

    task automatic rsp_ack();
        rsp_ready_i = 1'b1;
        @(negedge usr_clk);
        rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        usr_rst = 1'b1;
        repeat (3) @(negedge usr_clk);
        n_cmp++;
        if (cmd_ready_o !== 1'b0) begin
            n_bad++; $display("FAIL rst_cmd_ready: got %b want 0", cmd_ready_o);
        end
        n_cmp++;
        if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready} !== 5'b0) begin
            n_bad++; $display("FAIL rst_bus_hs: got %b want 00000",
                {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready});
        end
        n_cmp++;
        if ({rsp_valid_o, rsp_timeout_o, rsp_resp_o} !== 4'b0) begin
            n_bad++; $display("FAIL rst_rsp_ctl: got %b want 0000", {rsp_valid_o, rsp_timeout_o, rsp_resp_o});
        end
        n_cmp++;
        if (rsp_rdata_o !== 32'h0 || err_cnt_o !== 16'h0) begin
            n_bad++; $display("FAIL rst_rsp_data: rdata=%h err=%h want 0/0", rsp_rdata_o, err_cnt_o);
        end
        n_cmp++;
        if (bus.awaddr !== 32'h0 || bus.wdata !== 32'h0 || bus.wstrb !== 4'h0 ||
            bus.awprot !== 3'b000 || bus.arprot !== 3'b000) begin
            n_bad++; $display("FAIL rst_bus_data: awaddr=%h wdata=%h wstrb=%h awprot=%b arprot=%b want zeros",
                bus.awaddr, bus.wdata, bus.wstrb, bus.awprot, bus.arprot);
        end
        usr_rst = 1'b0;
        @(negedge usr_clk);
        n_cmp++;
        if (cmd_ready_o !== 1'b1) begin
            n_bad++; $display("FAIL idle_cmd_ready: got %b want 1", cmd_ready_o);
        end
    endtask

    task automatic test_write_toggle();
        int aw0, w0, b0, r0;
        bit ok;
        cfg_toggle = 1'b1;
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; r0 = rsp_cnt;
        send_cmd(1'b1, 32'h0001_0000, 32'h0000_0003, 4'hF);
        wait_rsp(ok);
        if (ok) begin
            n_cmp++;
            if (rsp_resp_o !== 2'b00) begin n_bad++; $display("FAIL wr_tgl_resp: got %b want 00", rsp_resp_o); end
            n_cmp++;
            if (rsp_rdata_o !== 32'h0) begin n_bad++; $display("FAIL wr_tgl_rdata: got %h want 0", rsp_rdata_o); end
            n_cmp++;
            if (err_cnt_o !== 16'd0) begin n_bad++; $display("FAIL wr_tgl_err: got %0d want 0", err_cnt_o); end
            n_cmp++;
            if (aw_cnt - aw0 != 1 || w_cnt - w0 != 1 || b_cnt - b0 != 1) begin
                n_bad++; $display("FAIL wr_tgl_hs: aw=%0d w=%0d b=%0d want 1/1/1", aw_cnt - aw0, w_cnt - w0, b_cnt - b0);
            end
            n_cmp++;
            if (mon_awaddr !== 32'h0001_0000 || mon_wdata !== 32'h3 || mon_wstrb !== 4'hF) begin
                n_bad++; $display("FAIL wr_tgl_fields: awaddr=%h wdata=%h wstrb=%h want 00010000/00000003/f",
                    mon_awaddr, mon_wdata, mon_wstrb);
            end
            rsp_ack();
            n_cmp++;
            if (rsp_cnt - r0 != 1) begin n_bad++; $display("FAIL wr_tgl_rspcnt: got %0d want 1", rsp_cnt - r0); end
        end
        cfg_toggle = 1'b0;
    endtask

    task automatic test_aw_before_w();
        int aw0, w0, b0, r0;
        bit ok;
        cfg_w_dly = 5;
        aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; r0 = rsp_cnt;
        send_cmd(1'b1, 32'h0001_0004, 32'hCAFE_0001, 4'h3);
        @(negedge usr_clk);
        n_cmp++;
        if (bus.awvalid !== 1'b0 || bus.wvalid !== 1'b1) begin
            n_bad++; $display("FAIL aw_first_split: awvalid=%b wvalid=%b want 0/1", bus.awvalid, bus.wvalid);
        end
        repeat (2) @(negedge usr_clk);
        n_cmp++;
        if (bus.wvalid !== 1'b1 || bus.wdata !== 32'hCAFE_0001) begin
            n_bad++; $display("FAIL aw_first_whold: wvalid=%b wdata=%h want 1/cafe0001", bus.wvalid, bus.wdata);
        end
        wait_rsp(ok);
        if (ok) begin
            n_cmp++;
            if (aw_cnt - aw0 != 1 || w_cnt - w0 != 1 || b_cnt - b0 != 1) begin
                n_bad++; $display("FAIL aw_first_hs: aw=%0d w=%0d b=%0d want 1/1/1", aw_cnt - aw0, w_cnt - w0, b_cnt - b0);
            end
            n_cmp++;
            if (rsp_resp_o !== 2'b00) begin n_bad++; $display("FAIL aw_first_resp: got %b want 00", rsp_resp_o); end
            rsp_ack();
            n_cmp++;
            if (rsp_cnt - r0 != 1) begin n_bad++; $display("FAIL aw_first_rspcnt: got %0d want 1", rsp_cnt - r0); end
        end
        cfg_w_dly = 0;
    endtask

    task automatic test_read_hold();
        bit ok;
        cfg_rdata = 32'h1234_5678;
        send_cmd(1'b0, 32'h0001_0004, 32'h0, 4'h0);
        wait_rsp(ok);
        if (ok) begin
            repeat (3) @(negedge usr_clk);
            n_cmp++;
            if (rsp_valid_o !== 1'b1) begin n_bad++; $display("FAIL rd_hold_valid: got %b want 1", rsp_valid_o); end
            n_cmp++;
            if (rsp_rdata_o !== 32'h1234_5678) begin n_bad++; $display("FAIL rd_rdata: got %h want 12345678", rsp_rdata_o); end
            n_cmp++;
            if (rsp_resp_o !== 2'b00 || rsp_timeout_o !== 1'b0) begin
                n_bad++; $display("FAIL rd_resp: resp=%b tmo=%b want 00/0", rsp_resp_o, rsp_timeout_o);
            end
            n_cmp++;
            if (mon_araddr !== 32'h0001_0004) begin n_bad++; $display("FAIL rd_araddr: got %h want 00010004", mon_araddr); end
            rsp_ack();
            n_cmp++;
            if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
                n_bad++; $display("FAIL rd_after_ack: rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid_o, cmd_ready_o);
            end
        end
        cfg_rdata = 32'h0;
    endtask

    task automatic test_bresp_err();
        bit ok;
        cfg_bresp = 2'b11;
        send_cmd(1'b1, 32'h0001_0008, 32'h0000_00A5, 4'h1);
        wait_rsp(ok);
        if (ok) begin
            n_cmp++;
            if (rsp_resp_o !== 2'b11) begin n_bad++; $display("FAIL berr_resp: got %b want 11", rsp_resp_o); end
            n_cmp++;
            if (err_cnt_o !== 16'd1) begin n_bad++; $display("FAIL berr_errcnt: got %0d want 1", err_cnt_o); end
            n_cmp++;
            if (rsp_timeout_o !== 1'b0) begin n_bad++; $display("FAIL berr_tmo: got %b want 0", rsp_timeout_o); end
            rsp_ack();
        end
        cfg_bresp = 2'b00;
    endtask

    task automatic test_read_timeout();
        int hi;
        int r0;
        bit ok;
        cfg_ar_never = 1'b1;
        cfg_rdata    = 32'hFFFF_FFFF;
        r0 = r_cnt;
        send_cmd(1'b0, 32'h0001_000C, 32'h0, 4'h0);
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.arvalid === 1'b1) hi++;
            else if (hi > 0) break;
            @(negedge usr_clk);
        end
        n_cmp++;
        if (hi != TMO) begin n_bad++; $display("FAIL tmo_arvalid_len: got %0d cycles want %0d", hi, TMO); end
        wait_rsp(ok);
        if (ok) begin
            n_cmp++;
            if (rsp_resp_o !== 2'b10 || rsp_timeout_o !== 1'b1) begin
                n_bad++; $display("FAIL tmo_resp: resp=%b tmo=%b want 10/1", rsp_resp_o, rsp_timeout_o);
            end
            n_cmp++;
            if (rsp_rdata_o !== 32'h0) begin n_bad++; $display("FAIL tmo_rdata: got %h want 0", rsp_rdata_o); end
            n_cmp++;
            if (err_cnt_o !== 16'd2) begin n_bad++; $display("FAIL tmo_errcnt: got %0d want 2", err_cnt_o); end
            n_cmp++;
            if ({bus.arvalid, bus.rready} !== 2'b00 || r_cnt != r0) begin
                n_bad++; $display("FAIL tmo_bus_idle: arvalid=%b rready=%b rhs=%0d want 0/0/0",
                    bus.arvalid, bus.rready, r_cnt - r0);
            end
            rsp_ack();
        end
        cfg_ar_never = 1'b0;
        cfg_rdata    = 32'h0;
    endtask

    task automatic test_reset_mid();
        int n;
        bit ok;
        cfg_b_hold = 1'b1;
        send_cmd(1'b1, 32'h0001_0010, 32'hDEAD_BEEF, 4'hF);
        n = 0;
        while (bus.bready !== 1'b1 && n < 50) begin
            @(negedge usr_clk);
            n++;
        end
        n_cmp++;
        if (bus.bready !== 1'b1) begin n_bad++; $display("FAIL rstmid_reach_wresp: bready=%b want 1", bus.bready); end
        usr_rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready} !== 5'b0) begin
            n_bad++; $display("FAIL rstmid_bus_hs: got %b want 00000",
                {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready});
        end
        n_cmp++;
        if (rsp_valid_o !== 1'b0 || err_cnt_o !== 16'd0 || cmd_ready_o !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_ctl: rsp_valid=%b err=%0d cmd_ready=%b want 0/0/0",
                rsp_valid_o, err_cnt_o, cmd_ready_o);
        end
        n_cmp++;
        if (bus.awaddr !== 32'h0 || bus.wdata !== 32'h0) begin
            n_bad++; $display("FAIL rstmid_data: awaddr=%h wdata=%h want 0/0", bus.awaddr, bus.wdata);
        end
        repeat (2) @(negedge usr_clk);
        usr_rst    = 1'b0;
        cfg_b_hold = 1'b0;
        repeat (3) @(negedge usr_clk);
        n_cmp++;
        if (rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            n_bad++; $display("FAIL rstmid_idle: rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid_o, cmd_ready_o);
        end
        send_cmd(1'b1, 32'h0001_0014, 32'h0000_0055, 4'hF);
        wait_rsp(ok);
        if (ok) begin
            n_cmp++;
            if (rsp_resp_o !== 2'b00 || err_cnt_o !== 16'd0) begin
                n_bad++; $display("FAIL rstmid_next_resp: resp=%b err=%0d want 00/0", rsp_resp_o, err_cnt_o);
            end
            rsp_ack();
            n_cmp++;
            if (rsp_cnt != 1 || b_cnt != 1 || mon_wdata !== 32'h55) begin
                n_bad++; $display("FAIL rstmid_next_hs: rsp=%0d b=%0d wdata=%h want 1/1/00000055",
                    rsp_cnt, b_cnt, mon_wdata);
            end
        end
    endtask

    initial begin
        usr_rst     = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_wr_i    = 1'b0;
        cmd_addr_i  = 32'h0;
        cmd_wdata_i = 32'h0;
        cmd_wstrb_i = 4'h0;
        rsp_ready_i = 1'b0;
        test_reset();
        test_write_toggle();
        test_aw_before_w();
        test_read_hold();
        test_bresp_err();
        test_read_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
